// File: rtl/imm_pkg.sv
// rtl/imm_pkg.sv - format codes and major-opcode constants for the immediate-decode stage
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_R       = 3'b000,
      FMT_I       = 3'b001,
      FMT_S       = 3'b010,
      FMT_B       = 3'b011,
      FMT_U       = 3'b100,
      FMT_J       = 3'b101,
      FMT_ILLEGAL = 3'b111
   } fmt_e;

   localparam logic [6:0] OP_LUI      = 7'b0110111;
   localparam logic [6:0] OP_AUIPC    = 7'b0010111;
   localparam logic [6:0] OP_JAL      = 7'b1101111;
   localparam logic [6:0] OP_BRANCH   = 7'b1100011;
   localparam logic [6:0] OP_STORE    = 7'b0100011;
   localparam logic [6:0] OP_JALR     = 7'b1100111;
   localparam logic [6:0] OP_LOAD     = 7'b0000011;
   localparam logic [6:0] OP_IMM      = 7'b0010011;
   localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
   localparam logic [6:0] OP_OP       = 7'b0110011;
   // RV64-only word forms
   localparam logic [6:0] OP_IMM_32   = 7'b0011011;
   localparam logic [6:0] OP_32       = 7'b0111011;

endpackage

// File: rtl/imm_decode_stage_if.sv
// rtl/imm_decode_stage_if.sv - fetch/execute handshake bundle; out_target exists only with IMMGEN_TARGET_EN
interface imm_decode_stage_if #(
   parameter int XLEN = 32
);

   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_instr;
   logic [XLEN-1:0] in_pc;

   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] out_imm;
   logic [2:0]      out_fmt;
   logic [XLEN-1:0] out_pc;

`ifdef IMMGEN_TARGET_EN
   logic [XLEN-1:0] out_target;

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_pc, out_target
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_pc, out_target
   );
`else
   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_imm, out_fmt, out_pc
   );

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_imm, out_fmt, out_pc
   );
`endif

endinterface

// File: rtl/imm_extract.sv
// rtl/imm_extract.sv - combinational instruction -> {format, sign-extended immediate}
module imm_extract
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output fmt_e            fmt,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      fmt = FMT_ILLEGAL;
      case (instr[6:0])
         OP_LUI, OP_AUIPC:  fmt = FMT_U;
         OP_JAL:            fmt = FMT_J;
         OP_BRANCH:         fmt = FMT_B;
         OP_STORE:          fmt = FMT_S;
         OP_JALR, OP_LOAD, OP_IMM, OP_MISC_MEM, OP_SYSTEM:
                            fmt = FMT_I;
         OP_OP:             fmt = FMT_R;
         OP_IMM_32:         if (XLEN == 64) fmt = FMT_I;
         OP_32:             if (XLEN == 64) fmt = FMT_R;
         default:           fmt = FMT_ILLEGAL;
      endcase
   end

   // Every layout carries its sign in instr[31]; build 32 bits, then widen.
   always_comb begin
      imm32 = '0;
      case (fmt)
         FMT_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
         FMT_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         FMT_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         FMT_U:   imm32 = {instr[31:12], 12'b0};
         FMT_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_decode_stage.sv
// rtl/imm_decode_stage.sv - decode at accept, 2-entry elastic buffer, saturating illegal counter
// IMMGEN_TARGET_EN adds a pc+imm adder and per-entry target storage.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   imm_decode_stage_if.slave bus,
   output logic [CNT_W-1:0] illegal_cnt
);

   fmt_e            in_fmt;
   logic [XLEN-1:0] in_imm;

   imm_extract #(.XLEN(XLEN)) u_extract (
      .instr (bus.in_instr),
      .fmt   (in_fmt),
      .imm   (in_imm)
   );

   logic [1:0]       count_q, count_d;
   logic             head_q, head_d;
   logic             tail_q, tail_d;
   logic             in_ready_q, in_ready_d;
   logic             out_valid_q, out_valid_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [XLEN-1:0]  imm_q [2];
   logic [XLEN-1:0]  imm_d [2];
   logic [2:0]       fmt_q [2];
   logic [2:0]       fmt_d [2];
   logic [XLEN-1:0]  pc_q  [2];
   logic [XLEN-1:0]  pc_d  [2];

`ifdef IMMGEN_TARGET_EN
   logic [XLEN-1:0]  target_q [2];
   logic [XLEN-1:0]  target_d [2];
   logic [XLEN-1:0]  in_target;

   // R/ILLEGAL carry imm=0, so their target naturally equals pc.
   assign in_target = bus.in_pc + in_imm;
`endif

   logic push;
   logic pop;

   // A flushed cycle never writes an entry, but a pop in that cycle still completes.
   assign push = bus.in_valid && in_ready_q && !flush;
   assign pop  = out_valid_q && bus.out_ready;

   always_comb begin
      imm_d   = imm_q;
      fmt_d   = fmt_q;
      pc_d    = pc_q;
`ifdef IMMGEN_TARGET_EN
      target_d = target_q;
`endif
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      cnt_d   = cnt_q;

      if (push) begin
         imm_d[tail_q] = in_imm;
         fmt_d[tail_q] = in_fmt;
         pc_d[tail_q]  = bus.in_pc;
`ifdef IMMGEN_TARGET_EN
         target_d[tail_q] = in_target;
`endif
         tail_d = ~tail_q;
         if (in_fmt == FMT_ILLEGAL && cnt_q != '1) begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end

      if (pop) begin
         head_d = ~head_q;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase

      if (flush) begin
         count_d = 2'd0;
         head_d  = 1'b0;
         tail_d  = 1'b0;
      end

      in_ready_d  = (count_d != 2'd2);
      out_valid_d = (count_d != 2'd0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q     <= 2'd0;
         head_q      <= 1'b0;
         tail_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         cnt_q       <= '0;
         for (int i = 0; i < 2; i++) begin
            imm_q[i] <= '0;
            fmt_q[i] <= '0;
            pc_q[i]  <= '0;
`ifdef IMMGEN_TARGET_EN
            target_q[i] <= '0;
`endif
         end
      end else begin
         count_q     <= count_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         cnt_q       <= cnt_d;
         for (int i = 0; i < 2; i++) begin
            imm_q[i] <= imm_d[i];
            fmt_q[i] <= fmt_d[i];
            pc_q[i]  <= pc_d[i];
`ifdef IMMGEN_TARGET_EN
            target_q[i] <= target_d[i];
`endif
         end
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_imm   = imm_q[head_q];
   assign bus.out_fmt   = fmt_q[head_q];
   assign bus.out_pc    = pc_q[head_q];
`ifdef IMMGEN_TARGET_EN
   assign bus.out_target = target_q[head_q];
`endif
   assign illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// tb/tb_imm_decode_stage.sv - table-driven scoreboard bench for imm_decode_stage (XLEN 32/64, CNT_W 16/2)
`timescale 1ns/1ps
module tb_imm_decode_stage;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [2:0]  fmt32;
      logic [31:0] imm32;
      logic [2:0]  fmt64;
      logic [63:0] imm64;
   } vec_t;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic        flush = 1'b0;
   logic [15:0] illegal_cnt;
   logic [1:0]  illegal_cnt2;
   logic [15:0] illegal_cnt64;

   imm_decode_stage_if #(.XLEN(32)) bus   ();
   imm_decode_stage_if #(.XLEN(32)) bus2  ();
   imm_decode_stage_if #(.XLEN(64)) bus64 ();

   always #5 clk = ~clk;

   imm_decode_stage #(.XLEN(32), .CNT_W(16)) u_dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus), .illegal_cnt(illegal_cnt));
   imm_decode_stage #(.XLEN(32), .CNT_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus2), .illegal_cnt(illegal_cnt2));
   imm_decode_stage #(.XLEN(64), .CNT_W(16)) u_dut64 (
      .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus64), .illegal_cnt(illegal_cnt64));

   assign bus2.in_valid   = bus.in_valid;
   assign bus2.in_instr   = bus.in_instr;
   assign bus2.in_pc      = bus.in_pc;
   assign bus2.out_ready  = bus.out_ready;
   assign bus64.in_valid  = bus.in_valid;
   assign bus64.in_instr  = bus.in_instr;
   assign bus64.in_pc     = {32'b0, bus.in_pc};
   assign bus64.out_ready = bus.out_ready;

   int   errors = 0;
   int   checks = 0;
   vec_t sb_q[$];
   vec_t pend;
   int   cnt_m  = 0;
   int   cnt2_m = 0;

   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endfunction

   // Scoreboard: counters, then pop on output transfer, then push on input transfer.
   always @(negedge clk) begin
      vec_t e;
      if (!rst_n) begin
         sb_q.delete();
         cnt_m  = 0;
         cnt2_m = 0;
      end else begin
         chk("illegal_cnt", 64'(illegal_cnt), 64'(cnt_m));
         chk("illegal_cnt_sat", 64'(illegal_cnt2), 64'(cnt2_m));
         if (bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_output", 64'd1, 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("fmt32", 64'(bus.out_fmt), 64'(e.fmt32));
               chk("imm32", 64'(bus.out_imm), 64'(e.imm32));
               chk("pc32", 64'(bus.out_pc), 64'(e.pc));
               chk("valid64", 64'(bus64.out_valid), 64'd1);
               chk("fmt64", 64'(bus64.out_fmt), 64'(e.fmt64));
               chk("imm64", bus64.out_imm, e.imm64);
               chk("pc64", bus64.out_pc, 64'(e.pc));
`ifdef IMMGEN_TARGET_EN
               chk("target32", 64'(bus.out_target), 64'(32'(e.pc + e.imm32)));
               chk("target64", bus64.out_target, 64'(e.pc) + e.imm64);
`endif
            end
         end
         if (flush) begin
            sb_q.delete();
         end else if (bus.in_valid && bus.in_ready) begin
            sb_q.push_back(pend);
            if (pend.fmt32 == 3'b111) begin
               cnt_m++;
               if (cnt2_m < 3) cnt2_m++;
            end
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input vec_t v, output int waited);
      bus.in_valid = 1'b1;
      bus.in_instr = v.instr;
      bus.in_pc    = v.pc;
      pend         = v;
      waited       = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!bus.in_ready) chk("accept_timeout", 64'd0, 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (sb_q.size() != 0 && n < 50);
      chk("drain", 64'(sb_q.size()), 64'd0);
   endtask

   task automatic chk_zero_outputs(string tag);
      chk({tag, "_out_valid"}, 64'(bus.out_valid), 64'd0);
      chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
      chk({tag, "_out_imm"}, 64'(bus.out_imm), 64'd0);
      chk({tag, "_out_fmt"}, 64'(bus.out_fmt), 64'd0);
      chk({tag, "_out_pc"}, 64'(bus.out_pc), 64'd0);
      chk({tag, "_imm64"}, bus64.out_imm, 64'd0);
      chk({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'd0);
      chk({tag, "_illegal_cnt_sat"}, 64'(illegal_cnt2), 64'd0);
`ifdef IMMGEN_TARGET_EN
      chk({tag, "_out_target"}, 64'(bus.out_target), 64'd0);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t tbl[16];
      vec_t ill;
      vec_t a, b, c;
      int   w;
      int   stalls;

      tbl[0]  = '{32'hFFF00093, 32'h0000_1000, 3'b001, 32'hFFFF_FFFF, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[1]  = '{32'hFE000EE3, 32'h0000_0100, 3'b011, 32'hFFFF_FFFC, 3'b011, 64'hFFFF_FFFF_FFFF_FFFC};
      tbl[2]  = '{32'h123450B7, 32'h0000_1008, 3'b100, 32'h1234_5000, 3'b100, 64'h0000_0000_1234_5000};
      tbl[3]  = '{32'h800000B7, 32'h8000_0000, 3'b100, 32'h8000_0000, 3'b100, 64'hFFFF_FFFF_8000_0000};
      tbl[4]  = '{32'h00001097, 32'h0000_1010, 3'b100, 32'h0000_1000, 3'b100, 64'h0000_0000_0000_1000};
      tbl[5]  = '{32'h0080006F, 32'h0000_1014, 3'b101, 32'h0000_0008, 3'b101, 64'h0000_0000_0000_0008};
      tbl[6]  = '{32'hFFDFF06F, 32'h0000_1018, 3'b101, 32'hFFFF_FFFC, 3'b101, 64'hFFFF_FFFF_FFFF_FFFC};
      tbl[7]  = '{32'h00112623, 32'h0000_101C, 3'b010, 32'h0000_000C, 3'b010, 64'h0000_0000_0000_000C};
      tbl[8]  = '{32'hFE112E23, 32'h0000_1020, 3'b010, 32'hFFFF_FFFC, 3'b010, 64'hFFFF_FFFF_FFFF_FFFC};
      tbl[9]  = '{32'h002081B3, 32'h0000_1024, 3'b000, 32'h0000_0000, 3'b000, 64'h0};
      tbl[10] = '{32'h7FF02083, 32'h0000_1028, 3'b001, 32'h0000_07FF, 3'b001, 64'h0000_0000_0000_07FF};
      tbl[11] = '{32'h00008067, 32'h0000_102C, 3'b001, 32'h0000_0000, 3'b001, 64'h0};
      tbl[12] = '{32'h0FF0000F, 32'h0000_1030, 3'b001, 32'h0000_00FF, 3'b001, 64'h0000_0000_0000_00FF};
      tbl[13] = '{32'hFFF0809B, 32'h0000_1034, 3'b111, 32'h0000_0000, 3'b001, 64'hFFFF_FFFF_FFFF_FFFF};
      tbl[14] = '{32'h002080BB, 32'h0000_1038, 3'b111, 32'h0000_0000, 3'b000, 64'h0};
      tbl[15] = '{32'h0000007F, 32'hFFFF_FFFC, 3'b111, 32'h0000_0000, 3'b111, 64'h0};
      ill     = '{32'h0000007F, 32'h0000_2000, 3'b111, 32'h0000_0000, 3'b111, 64'h0};

      bus.in_valid  = 1'b0;
      bus.in_instr  = '0;
      bus.in_pc     = '0;
      bus.out_ready = 1'b1;
      pend          = ill;

      repeat (2) @(posedge clk);
      #1;
      chk_zero_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      stalls = 0;
      for (int i = 0; i < 16; i++) begin
         send(tbl[i], w);
         stalls += w;
      end
      chk("stream_stalls", 64'(stalls), 64'd0);
      drain();

      // Single accept into an empty buffer shows up one cycle later.
      bus.in_valid = 1'b1;
      bus.in_instr = tbl[1].instr;
      bus.in_pc    = tbl[1].pc;
      pend         = tbl[1];
      @(negedge clk);
      chk("latency_idle_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("latency_out_valid", 64'(bus.out_valid), 64'd1);
      @(posedge clk);
      #1;

      // Backpressure: two accepted, third held off, head stable.
      a = tbl[2]; b = tbl[6]; c = tbl[8];
      bus.out_ready = 1'b0;
      send(a, w);
      send(b, w);
      chk("bp_second_no_wait", 64'(w), 64'd0);
      bus.in_valid = 1'b1;
      bus.in_instr = c.instr;
      bus.in_pc    = c.pc;
      pend         = c;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_hold_pc", 64'(bus.out_pc), 64'(a.pc));
         chk("bp_hold_imm", 64'(bus.out_imm), 64'(a.imm32));
         @(posedge clk);
         #1;
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_registered", 64'(bus.in_ready), 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("bp_in_ready_return", 64'(bus.in_ready), 64'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      drain();

      for (int i = 0; i < 5; i++) send(ill, w);
      drain();
      chk("illegal_total", 64'(illegal_cnt), 64'd8);
      chk("illegal_saturated", 64'(illegal_cnt2), 64'd3);
      chk("illegal_out_fmt", 64'(bus.out_fmt), 64'h7);
      chk("illegal_out_imm", 64'(bus.out_imm), 64'd0);

      // Flush at full occupancy with an offered illegal instruction.
      bus.out_ready = 1'b0;
      send(tbl[0], w);
      send(tbl[2], w);
      bus.in_valid = 1'b1;
      bus.in_instr = ill.instr;
      bus.in_pc    = ill.pc;
      pend         = ill;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_in_ready", 64'(bus.in_ready), 64'd1);
      chk("flush_cnt_kept", 64'(illegal_cnt), 64'd8);

      // Flush coinciding with an accept into an empty buffer drops it uncounted.
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      flush        = 1'b1;
      @(posedge clk);
      #1;
      flush        = 1'b0;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("flush_drop_valid", 64'(bus.out_valid), 64'd0);
      chk("flush_drop_cnt", 64'(illegal_cnt), 64'd8);
      @(posedge clk);
      #1;

      // Asynchronous reset between edges with two entries buffered.
      send(tbl[1], w);
      send(tbl[15], w);
      #1;
      rst_n = 1'b0;
      #1;
      chk_zero_outputs("async_reset");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("reset_sb_empty", 64'(sb_q.size()), 64'd0);
      chk("reset_no_output", 64'(bus.out_valid), 64'd0);

      send(tbl[3], w);
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
